ssd_display_arbiter: RTL
========================

Name: ssd_display_arbiter

Overview:
- Shares the single 8-digit seven-segment display between NREQ requesters, such as pipeline debug taps, the UART RX byte log and the PC/instruction monitor.
- Round-robin arbitration with a guaranteed minimum on-screen hold time per owner.
- Drives the 32-bit word and a source tag into the seven-segment decoder's data input.
- Sits between the pipeline/UART debug sources and the display decoder in the board top level.

Parameters:
- DW, 32, display word width (8 hex digits).
- NREQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 50000000, minimum clk cycles an owner stays displayed before another source may take over; must be >= 1.
- SRC_W, $clog2(NREQ), width of the source index (derived, not overridable).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req_valid_i  input  NREQ  per-requester request; held high until acked.
- req_data_i  input  NREQ*DW  packed request words; requester k occupies bits [k*DW +: DW].
- req_ack_o  output  NREQ  one-hot, single-cycle pulse; word latched this cycle.
- freeze_i  input  1  level; while high, ownership does not change.
- disp_data_o  output  DW  word to the display decoder.
- disp_valid_o  output  1  high once any word has been latched.
- disp_src_o  output  SRC_W  index of the current owner.
- hold_done_o  output  1  hold interval for the current owner has elapsed.

Behaviour:
- Reset (reset==0, asynchronous) clears all of the following:
  - Outputs: disp_data_o=0, disp_valid_o=0, disp_src_o=0, req_ack_o=0, hold_done_o=0.
  - Internal: hold counter=0, state=IDLE, round-robin pointer=0.
- Reset applied mid-hold aborts the hold. Pending requests are re-arbitrated after release.
- State IDLE:
  - Nothing displayed.
  - On the first cycle any req_valid_i bit is high, grant via round-robin from the pointer.
  - The grant latches the data and pulses req_ack_o[k] in the same registered cycle; outputs update on that edge (1-cycle latency from valid to ack/display).
  - Then go to HOLD with counter=0.
- State HOLD:
  - Counter increments each cycle.
  - When counter reaches HOLD_CYCLES-1, go to OPEN and set hold_done_o=1.
- State OPEN:
  - Hold expired; the owner keeps displaying.
  - If freeze_i==0 and any non-owner req_valid_i is high, grant the next requester searching from owner+1 with wrap-around.
  - A grant latches, acks, sets the pointer to the new owner, returns to HOLD, clears the counter and sets hold_done_o=0.
- Same-source update, in HOLD or OPEN:
  - If req_valid_i[owner]=1, the data is latched and acked that cycle.
  - The state and counter are unchanged, so the hold is not restarted.
- Simultaneous owner update and non-owner grant in OPEN: the non-owner wins. The owner's request stays pending and is not acked.
- freeze_i=1 blocks non-owner grants only. Same-source updates are still accepted and the counter still runs. Dropping freeze in OPEN allows a grant on the next edge.
- At most one req_ack_o bit is high in any cycle. Acks are never issued to a requester whose valid is low.
- The counter width is $clog2(HOLD_CYCLES+1). HOLD_CYCLES==1 means a new owner becomes eligible one cycle after a grant.
- Requester behaviour is out of scope: dropping valid without an ack is legal, and that request is simply never served.

Decomposition:
- Package ssd_pkg holds:
  - the arb_state_e enum (IDLE, HOLD, OPEN);
  - the NO_OF_DIGITS=8 constant;
  - a function returning the next round-robin index from (mask, pointer).
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req mask and pointer.
  - Outputs: one-hot grant and index.
  - Also reusable by a future UART TX arbiter.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles then release, no requests for 20 cycles -> disp_valid_o=0, disp_data_o=0, req_ack_o=0 throughout.
2. Single request: HOLD_CYCLES=8; req_valid_i=4'b0010 with req 1 data 32'hDEADBEEF:
   - next edge: req_ack_o=4'b0010, disp_data_o=32'hDEADBEEF, disp_src_o=1;
   - hold_done_o rises exactly 8 cycles after the ack.
3. Round-robin fairness: all four valid continuously, each re-raising valid after its ack:
   - grants run 0,1,2,3,0;
   - consecutive acks are spaced exactly 8 cycles apart.
4. Same-source update: owner 2 re-requests with 32'h00000055 at cycle 3 of hold -> ack that cycle, display updates, and hold_done_o still rises at the original cycle 8.
5. Freeze: owner 0 in OPEN, req 3 valid, freeze_i=1 for 30 cycles -> no ack for req 3. freeze_i to 0 -> ack[3] on the next edge.
6. Reset mid-hold: reset=0 at hold cycle 4 -> all outputs return to zero asynchronously. After release with req 1 still valid -> req 1 is acked on the first edge.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ssd_pkg : shared types and round-robin helper for the display arbiter      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } arb_state_e;

  localparam int NO_OF_DIGITS = 8;
  localparam int MAX_REQ      = 8;

  // Returns {found, index} of the first set mask bit at or after start, wrapping at n.
  function automatic logic [3:0] rr_next(input logic [MAX_REQ-1:0] mask,
                                         input logic [2:0]         start,
                                         input int                 n);
    logic [3:0] r;
    int         j;
    r = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        j = int'(start) + i;
        if (j >= n) j = j - n;
        if (mask[j[2:0]]) r = {1'b1, j[2:0]};
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick : combinational round-robin selector (one-hot grant plus index)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick
  import ssd_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [MAX_REQ-1:0] w_mask;
  logic [2:0]         w_start;
  logic [3:0]         w_pick;

  always_comb begin
    w_mask        = '0;
    w_mask[N-1:0] = i_req;
    w_start       = 3'(i_start);
    w_pick        = rr_next(w_mask, w_start, N);
    o_any         = w_pick[3];
    o_idx         = IW'(w_pick[2:0]);
    o_gnt         = '0;
    if (w_pick[3]) o_gnt[IW'(w_pick[2:0])] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/ssd_display_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ssd_display_arbiter : round-robin owner of the 8-digit display with hold   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int DW          = 32,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50000000,
  localparam int SRC_W      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ack_o,
  input  logic               freeze_i,
  output logic [DW-1:0]      disp_data_o,
  output logic               disp_valid_o,
  output logic [SRC_W-1:0]   disp_src_o,
  output logic               hold_done_o
);

  localparam int            CW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(HOLD_CYCLES - 1);

  arb_state_e        r_state,     w_state;
  logic [CW-1:0]     r_cnt,       w_cnt;
  logic [SRC_W-1:0]  r_ptr,       w_ptr;
  logic [SRC_W-1:0]  r_src,       w_src;
  logic [DW-1:0]     r_data,      w_data;
  logic              r_valid,     w_valid;
  logic [NREQ-1:0]   r_ack,       w_ack;
  logic              r_hold_done, w_hold_done;

  logic [NREQ-1:0]   w_owner_oh;
  logic [NREQ-1:0]   w_pick_mask;
  logic [SRC_W-1:0]  w_pick_start;
  logic [NREQ-1:0]   w_gnt;
  logic [SRC_W-1:0]  w_idx;
  logic              w_any;
  logic              w_expiring;
  logic              w_eligible;

  always_comb begin
    w_owner_oh        = '0;
    w_owner_oh[r_src] = 1'b1;
  end

  // Idle arbitration starts at the pointer itself; takeover searches past the owner.
  assign w_pick_mask  = (r_state == IDLE) ? req_valid_i : (req_valid_i & ~w_owner_oh);
  assign w_pick_start = (r_state == IDLE)                ? r_ptr :
                        (r_ptr == SRC_W'(NREQ - 1))      ? '0    : r_ptr + 1'b1;

  rr_pick #(.N(NREQ)) u_rr_pick (
    .i_req   (w_pick_mask),
    .i_start (w_pick_start),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The final hold cycle already counts as eligible, so a waiting source
  // takes over exactly HOLD_CYCLES after the previous grant.
  assign w_expiring = (r_state == HOLD) && (r_cnt == C_LAST);
  assign w_eligible = (r_state == OPEN) || w_expiring;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_ptr       = r_ptr;
    w_src       = r_src;
    w_data      = r_data;
    w_valid     = r_valid;
    w_ack       = '0;
    w_hold_done = r_hold_done;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state     = HOLD;
          w_cnt       = '0;
          w_ptr       = w_idx;
          w_src       = w_idx;
          w_data      = req_data_i[w_idx*DW +: DW];
          w_valid     = 1'b1;
          w_ack       = w_gnt;
          w_hold_done = 1'b0;
        end
      end
      HOLD, OPEN: begin
        if (w_eligible && !freeze_i && w_any) begin
          w_state     = HOLD;
          w_cnt       = '0;
          w_ptr       = w_idx;
          w_src       = w_idx;
          w_data      = req_data_i[w_idx*DW +: DW];
          w_ack       = w_gnt;
          w_hold_done = 1'b0;
        end else begin
          if (req_valid_i[r_src]) begin
            w_data = req_data_i[r_src*DW +: DW];
            w_ack  = w_owner_oh;
          end
          if (r_state == HOLD) begin
            if (w_expiring) begin
              w_state     = OPEN;
              w_hold_done = 1'b1;
            end else begin
              w_cnt = r_cnt + 1'b1;
            end
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_src       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ack       <= '0;
      r_hold_done <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_ptr       <= w_ptr;
      r_src       <= w_src;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_ack       <= w_ack;
      r_hold_done <= w_hold_done;
    end
  end

  assign req_ack_o    = r_ack;
  assign disp_data_o  = r_data;
  assign disp_valid_o = r_valid;
  assign disp_src_o   = r_src;
  assign hold_done_o  = r_hold_done;

endmodule
`default_nettype wire
